risc32_div_ctrl: RTL and testbench
==================================

// Module: risc32_div_ctrl
// PURPOSE
//   Multi-cycle divide sequencer for the execute stage; implements DIV/DIVU (signed/unsigned).
//   Execute holds start_i with operands; this block runs a restoring divider, one quotient bit
//   per cycle, and returns {remainder,quotient} for the HI/LO write.
//   Drives stall_o so the pipeline freezes until the result is ready.
// PARAMETERS
//   WIDTH   32   operand width; result_o is 2*WIDTH; counter width = $clog2(WIDTH)+1
// PORTS
//   clk            in   1         clock, rising edge
//   rst            in   1         asynchronous reset, active-low
//   start_i        in   1         divide request; held by execute until ready_o seen
//   annul_i        in   1         cancel in-flight divide (flush/exception)
//   signed_div_i   in   1         1 = DIV (two's complement), 0 = DIVU
//   opdata1_i      in   WIDTH     dividend (sampled at acceptance only)
//   opdata2_i      in   WIDTH     divisor  (sampled at acceptance only)
//   result_o       out  2*WIDTH   {remainder (->HI), quotient (->LO)}
//   ready_o        out  1         result_o valid
//   div_by_zero_o  out  1         divisor was zero; valid with ready_o
//   stall_o        out  1         combinational: start_i & ~ready_o
// BEHAVIOUR
//   Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, div_by_zero_o=0.
//   States FREE, BYZERO, ON, END (registered state; outputs registered except stall_o).
//   FREE:   start_i & ~annul_i -> accept: opdata2_i==0 -> BYZERO; else latch |dividend|,
//           |divisor| (negate only if signed_div_i and bit WIDTH-1 set), latch sign bits, cnt=0 -> ON.
//           start_i & annul_i -> stay FREE, nothing latched.
//   BYZERO: next edge -> END, result_o=0, div_by_zero_o=1, ready_o=1.
//   ON:     annul_i -> FREE, ready_o stays 0, partial state discarded (same edge).
//           else per edge: {rem,dvd}<<1; if rem>=|divisor| then rem-=|divisor|, shift in 1 else 0;
//           cnt++. On the edge completing step WIDTH: apply sign fix, load result_o, ready_o=1 -> END.
//   Sign fix (signed only): quotient negated if dividend/divisor signs differ; remainder takes
//           dividend sign. Unsigned: no fix. Overflow 0x80000000/-1 wraps: quot 0x80000000, rem 0.
//   END:    hold result_o, ready_o=1. start_i=0 -> FREE, ready_o=0, result_o=0,
//           div_by_zero_o=0. start_i=1 holds END (no re-trigger; start must drop first).
//           annul_i in END -> FREE as if start_i=0.
//   Latency: acceptance edge = edge 1; normal ready_o rises after edge WIDTH+1 (33);
//           divide-by-zero ready_o after edge 2.
//   stall_o=1 in FREE on request cycle through the last cycle before ready_o=1; 0 once
//           ready_o=1, and 0 whenever start_i=0.
//   Operand changes after acceptance are ignored. Reset mid-operation -> FREE immediately,
//           all outputs to reset values.
// CONFIGURATION
//   RISC32_DIV_EARLY_OUT_EN defined: in FREE, if |dividend| < |divisor| (incl. dividend 0,
//           divisor !=0) -> skip ON, go END on acceptance edge: quot=0, rem=original dividend
//           (signed value, no fix needed); ready_o after edge 1.
//   Undefined: all nonzero-divisor cases take full WIDTH-step path.
// TESTING
//   DIVU 100/7 -> result_o={32'd2,32'd14}, ready_o after edge 33, stall_o high cycles 1..33.
//   DIV -7/2 -> quot 32'hFFFFFFFD, rem 32'hFFFFFFFF; DIV 7/-2 -> quot 32'hFFFFFFFD, rem 32'd1.
//   DIV 32'h80000000/32'hFFFFFFFF -> quot 32'h80000000, rem 0, div_by_zero_o=0.
//   DIVU 5/0 -> ready_o after edge 2, result_o=0, div_by_zero_o=1; drop start -> FREE, flags 0.
//   DIVU 100/7, annul_i at edge 10 -> FREE, ready_o never rises; new DIVU 9/3 -> quot 3, rem 0.
//   rst low at edge 20 of a divide -> outputs 0 at once; with RISC32_DIV_EARLY_OUT_EN,
//           DIVU 5/9 -> quot 0, rem 5, ready_o after edge 1.

Source files
------------

// File: rtl/risc32_div_ctrl.sv
// Purpose: multi-cycle DIV/DIVU sequencer (restoring, one quotient bit per cycle) returning {rem,quot}.
// Latency: result after edge WIDTH+1 from acceptance; divide-by-zero after edge 2; early-out after edge 1.
// Backpressure: stall = start & ~ready; requester holds start until ready, then must drop it.
// Optional feature: define RISC32_DIV_EARLY_OUT_EN to finish |dividend| < |divisor| on the acceptance edge.
module risc32_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_by_zero_o,
  output logic               stall_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;       // partial remainder
  logic [WIDTH-1:0]   dvd, dvd_nxt;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvs, dvs_nxt;       // divisor magnitude
  logic               neg_dvd, neg_dvd_nxt;
  logic               neg_dvs, neg_dvs_nxt;
  logic [2*WIDTH-1:0] result_nxt;
  logic               ready_nxt;
  logic               dbz_nxt;

  // Operand sign and magnitude, only meaningful on the acceptance cycle
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign sign_a = signed_div_i & opdata1_i[WIDTH-1];
  assign sign_b = signed_div_i & opdata2_i[WIDTH-1];
  assign abs_a  = sign_a ? -opdata1_i : opdata1_i;
  assign abs_b  = sign_b ? -opdata2_i : opdata2_i;

  // One restoring step: trial is 33 bits because rem<<1 can exceed WIDTH bits
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   fix_quo;
  logic [WIDTH-1:0]   fix_rem;

  assign trial    = {rem, dvd[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs};
  assign fits     = (trial >= {1'b0, dvs});
  assign step_rem = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_quo = {dvd[WIDTH-2:0], fits};

  // Sign fix: flags are already zero for DIVU, so unsigned results pass through.
  // 0x80000000 / -1 naturally wraps back to 0x80000000 here.
  assign fix_quo  = (neg_dvd ^ neg_dvs) ? -step_quo : step_quo;
  assign fix_rem  = neg_dvd ? -step_rem : step_rem;

  // Stall the pipeline while a request is pending and no result is available yet
  assign stall_o = start_i & ~ready_o;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_FREE;
      cnt           <= '0;
      rem           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      neg_dvd       <= 1'b0;
      neg_dvs       <= 1'b0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rem           <= rem_nxt;
      dvd           <= dvd_nxt;
      dvs           <= dvs_nxt;
      neg_dvd       <= neg_dvd_nxt;
      neg_dvs       <= neg_dvs_nxt;
      result_o      <= result_nxt;
      ready_o       <= ready_nxt;
      div_by_zero_o <= dbz_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem_nxt     = rem;
    dvd_nxt     = dvd;
    dvs_nxt     = dvs;
    neg_dvd_nxt = neg_dvd;
    neg_dvs_nxt = neg_dvs;
    result_nxt  = result_o;
    ready_nxt   = ready_o;
    dbz_nxt     = div_by_zero_o;

    case (state)
      S_FREE: begin
        // An annulled request is dropped without latching anything
        if (start_i && !annul_i) begin
          cnt_nxt = '0;
          if (opdata2_i == '0) begin
            state_nxt = S_BYZERO;
`ifdef RISC32_DIV_EARLY_OUT_EN
          end else if (abs_a < abs_b) begin
            // Quotient is zero and the remainder is the dividend as given
            state_nxt  = S_END;
            result_nxt = {opdata1_i, {WIDTH{1'b0}}};
            ready_nxt  = 1'b1;
            dbz_nxt    = 1'b0;
`endif
          end else begin
            state_nxt   = S_ON;
            rem_nxt     = '0;
            dvd_nxt     = abs_a;
            dvs_nxt     = abs_b;
            neg_dvd_nxt = sign_a;
            neg_dvs_nxt = sign_b;
          end
        end
      end

      S_BYZERO: begin
        // Not cancellable: it is only one cycle from completion anyway
        state_nxt  = S_END;
        result_nxt = '0;
        ready_nxt  = 1'b1;
        dbz_nxt    = 1'b1;
      end

      S_ON: begin
        if (annul_i) begin
          state_nxt = S_FREE;
          cnt_nxt   = '0;
          rem_nxt   = '0;
          dvd_nxt   = '0;
          ready_nxt = 1'b0;
        end else begin
          rem_nxt = step_rem;
          dvd_nxt = step_quo;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state_nxt  = S_END;
            result_nxt = {fix_rem, fix_quo};
            ready_nxt  = 1'b1;
            dbz_nxt    = 1'b0;
          end
        end
      end

      S_END: begin
        // Hold the result until the requester drops start; no re-trigger while held
        if (!start_i || annul_i) begin
          state_nxt  = S_FREE;
          cnt_nxt    = '0;
          result_nxt = '0;
          ready_nxt  = 1'b0;
          dbz_nxt    = 1'b0;
        end
      end

      default: begin
        state_nxt  = S_FREE;
        result_nxt = '0;
        ready_nxt  = 1'b0;
        dbz_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_risc32_div_ctrl.sv
// Bench for risc32_div_ctrl: directed literal cases plus randomized requests against a reference model.
module tb_risc32_div_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic           sgn = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           dbz;
  logic           stall;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  risc32_div_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .annul_i       (annul),
    .signed_div_i  (sgn),
    .opdata1_i     (op1),
    .opdata2_i     (op2),
    .result_o      (result),
    .ready_o       (ready),
    .div_by_zero_o (dbz),
    .stall_o       (stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? -v : v;
  endfunction

  // Arithmetic reference: truncating division, remainder carries dividend sign
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  function automatic bit early(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef RISC32_DIV_EARLY_OUT_EN
    return (b != 32'd0) && (mag(a, s) < mag(b, s));
`else
    return 1'b0 && (a == b) && s;
`endif
  endfunction

  // Reference model: an idle/countdown/done view of the request lifecycle
  bit          m_ready  = 1'b0;
  bit          m_dbz    = 1'b0;
  bit          m_byzero = 1'b0;
  int          m_left   = 0;
  logic [63:0] m_res    = '0;
  logic [63:0] m_pend   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready  <= 1'b0;
      m_dbz    <= 1'b0;
      m_res    <= '0;
      m_left   <= 0;
      m_byzero <= 1'b0;
    end else if (m_ready) begin
      if (!start || annul) begin
        m_ready <= 1'b0;
        m_res   <= '0;
        m_dbz   <= 1'b0;
      end
    end else if (m_left > 0) begin
      if (annul && !m_byzero) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_ready  <= 1'b1;
          m_res    <= m_pend;
          m_dbz    <= m_byzero;
          m_byzero <= 1'b0;
        end
      end
    end else if (start && !annul) begin
      m_pend <= ref_div(op1, op2, sgn);
      if (op2 == '0) begin
        m_left   <= 1;
        m_byzero <= 1'b1;
      end else if (early(op1, op2, sgn)) begin
        m_ready <= 1'b1;
        m_res   <= ref_div(op1, op2, sgn);
        m_dbz   <= 1'b0;
      end else begin
        m_left   <= W;
        m_byzero <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("ready", 64'(ready), 64'(m_ready));
      chk("result", result, m_res);
      chk("div_by_zero", 64'(dbz), 64'(m_dbz));
      chk("stall", 64'(stall), 64'(start & ~m_ready));
    end
  end

  // Issue one request (called #1 after a rising edge); operands are scrambled after acceptance
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int annul_at, input int hold_extra,
                        output logic [63:0] res, output int edges,
                        output bit seen_ready, output bit seen_dbz);
    start      = 1'b1;
    op1        = a;
    op2        = b;
    sgn        = s;
    annul      = 1'b0;
    edges      = 0;
    res        = '0;
    seen_ready = 1'b0;
    seen_dbz   = 1'b0;
    while (!seen_ready) begin
      if (annul_at != 0 && edges + 1 == annul_at) annul = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      op1 = $urandom;
      op2 = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (ready) begin
        seen_ready = 1'b1;
        res        = result;
        seen_dbz   = dbz;
      end
      if (annul_at != 0 && edges == annul_at) break;
      if (edges > 100) begin
        checks++;
        errors++;
        $display("FAIL timeout: ready not seen after %0d edges, required within 34", edges);
        break;
      end
    end
    repeat (hold_extra) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    annul = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] res;
  int          edges;
  bit          seen_r, seen_z;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset dbz", 64'(dbz), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd100, 32'd7, 1'b0, 0, 0, res, edges, seen_r, seen_z);
    chk("divu 100/7 result", res, {32'd2, 32'd14});
    chk("divu 100/7 latency", 64'(edges), 64'd33);
    chk("divu 100/7 dbz", 64'(seen_z), 64'd0);

    run_op(-32'sd7, 32'd2, 1'b1, 0, 2, res, edges, seen_r, seen_z);
    chk("div -7/2 result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op(32'd7, -32'sd2, 1'b1, 0, 0, res, edges, seen_r, seen_z);
    chk("div 7/-2 result", res, {32'd1, 32'hFFFF_FFFD});

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, res, edges, seen_r, seen_z);
    chk("div overflow result", res, {32'd0, 32'h8000_0000});
    chk("div overflow dbz", 64'(seen_z), 64'd0);

    run_op(32'd5, 32'd0, 1'b0, 0, 1, res, edges, seen_r, seen_z);
    chk("divu 5/0 result", res, 64'd0);
    chk("divu 5/0 latency", 64'(edges), 64'd2);
    chk("divu 5/0 dbz", 64'(seen_z), 64'd1);
    chk("divu 5/0 dbz cleared", 64'(dbz), 64'd0);
    chk("divu 5/0 ready cleared", 64'(ready), 64'd0);

    run_op(32'd100, 32'd7, 1'b0, 10, 0, res, edges, seen_r, seen_z);
    chk("annul ready never", 64'(seen_r), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, 0, 0, res, edges, seen_r, seen_z);
    chk("divu 9/3 after annul", res, {32'd0, 32'd3});

    // Reset in the middle of a divide
    start = 1'b1;
    op1   = 32'd100;
    op2   = 32'd7;
    sgn   = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset ready", 64'(ready), 64'd0);
    chk("midreset result", result, 64'd0);
    chk("midreset dbz", 64'(dbz), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd5, 32'd9, 1'b0, 0, 0, res, edges, seen_r, seen_z);
    chk("divu 5/9 result", res, {32'd5, 32'd0});
`ifdef RISC32_DIV_EARLY_OUT_EN
    chk("divu 5/9 latency", 64'(edges), 64'd1);
`else
    chk("divu 5/9 latency", 64'(edges), 64'd33);
`endif
    run_op(-32'sd3, 32'd7, 1'b1, 0, 0, res, edges, seen_r, seen_z);
    chk("div -3/7 result", res, {32'hFFFF_FFFD, 32'd0});

    // Randomized requests; the per-cycle comparator checks them against the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      logic        s;
      int          pat, an, hold;
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      pat = $urandom_range(0, 9);
      case (pat)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: begin a = $urandom_range(0, 100); b = $urandom_range(101, 1000); end
        5: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      an   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : 0;
      hold = $urandom_range(0, 3);
      run_op(a, b, s, an, hold, res, edges, seen_r, seen_z);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
